video_level_mixer: RTL and testbench

Parametrised video output stage for the monochrome arcade cores. It turns NUM_IN one-bit video lines into an OUT_W-bit intensity through a run-time programmable lookup table. It generates the pixel clock-enable by dividing the video clock, and it delays sync and blank so they stay aligned with the pixel data. It sits between a core's raw video/sync outputs and the arcade video/scandoubler stage, and replaces per-core fixed two-line mappings and free-running divider logic.

---
 rtl/video_mix_pkg.sv | 21 ++
 rtl/pix_ce_div.sv | 26 ++
 rtl/video_level_mixer.sv | 94 +++++++++
 tb/tb_video_level_mixer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_mix_pkg.sv
// Shared constants and helpers for the video level mixer.
// Includes parameter limits, the reset ramp and the pipeline depth.
package video_mix_pkg;

  localparam int NUM_IN_MIN = 1;
  localparam int NUM_IN_MAX = 4;
  localparam int OUT_W_MIN  = 1;
  localparam int OUT_W_MAX  = 12;
  localparam int DIV_MIN    = 1;
  localparam int DIV_MAX    = 256;
  localparam int PIPE_LAT   = 2;

  function automatic int ramp_entry(
    input int i,
    input int n,
    input int w
  );
    return (i * ((1 << w) - 1)) / ((1 << n) - 1);
  endfunction

endpackage

// File: rtl/pix_ce_div.sv
// Pixel clock-enable divider: one-cycle strobe every DIV clocks.
// The strobe is registered, so the first one follows the DIV-th edge.
module pix_ce_div #(
  parameter int DIV = 8
) (
  input  logic clk_video,
  input  logic Reset_I,
  output logic ce_pix
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_video or negedge Reset_I) begin
    if (!Reset_I) begin
      cnt    <= '0;
      ce_pix <= 1'b0;
    end else begin
      ce_pix <= (cnt == LAST);
      cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/video_level_mixer.sv
// Maps one-bit video lines to an intensity via a programmable table.
// Two-strobe pipeline keeps sync and blank aligned with the pixel.
module video_level_mixer
  import video_mix_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int OUT_W  = 8,
  parameter int DIV    = 8
) (
  input  logic              clk_video,
  input  logic              Reset_I,
  input  logic [NUM_IN-1:0] video_in,
  input  logic              hblank_in,
  input  logic              vblank_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              tbl_wr,
  input  logic [NUM_IN-1:0] tbl_addr,
  input  logic [OUT_W-1:0]  tbl_data,
  input  logic              invert,
  output logic              ce_pix,
  output logic [OUT_W-1:0]  level_out,
  output logic              hblank_out,
  output logic              vblank_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out
);

  localparam int DEPTH = 1 << NUM_IN;

  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
    $fatal(1, "video_level_mixer: NUM_IN out of range");
  end
  if (OUT_W < OUT_W_MIN || OUT_W > OUT_W_MAX) begin : g_bad_out_w
    $fatal(1, "video_level_mixer: OUT_W out of range");
  end
  if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_bad_div
    $fatal(1, "video_level_mixer: DIV out of range");
  end

  logic [OUT_W-1:0]  tbl [DEPTH];
  logic [NUM_IN-1:0] vid1;
  logic              hb1;
  logic              vb1;
  logic              hs1;
  logic              vs1;

  pix_ce_div #(.DIV(DIV)) u_div (
    .clk_video (clk_video),
    .Reset_I   (Reset_I),
    .ce_pix    (ce_pix)
  );

  // Writes ignore ce_pix; a same-cycle lookup still sees the old entry.
  always_ff @(posedge clk_video or negedge Reset_I) begin
    if (!Reset_I) begin
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= OUT_W'(ramp_entry(i, NUM_IN, OUT_W));
    end else if (tbl_wr) begin
      tbl[tbl_addr] <= tbl_data;
    end
  end

  always_ff @(posedge clk_video or negedge Reset_I) begin
    if (!Reset_I) begin
      vid1       <= '0;
      hb1        <= 1'b0;
      vb1        <= 1'b0;
      hs1        <= 1'b0;
      vs1        <= 1'b0;
      level_out  <= '0;
      hblank_out <= 1'b0;
      vblank_out <= 1'b0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
    end else if (ce_pix) begin
      vid1       <= video_in;
      hb1        <= hblank_in;
      vb1        <= vblank_in;
      hs1        <= hs_in;
      vs1        <= vs_in;
      level_out  <= (hb1 | vb1) ? '0
                  : (tbl[vid1] ^ {OUT_W{invert}});
      hblank_out <= hb1;
      vblank_out <= vb1;
      hs_out     <= hs1;
      vs_out     <= vs1;
    end
  end

  assign de_out = ~(hblank_out | vblank_out);

endmodule

// File: tb/tb_video_level_mixer.sv
// Self-checking bench for video_level_mixer (NUM_IN=2, OUT_W=8).
// Queue-based reference model plus hand-computed literal vectors.
module tb_video_level_mixer;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] video_in = '0;
  logic       hblank_in = 1'b0;
  logic       vblank_in = 1'b0;
  logic       hs_in = 1'b0;
  logic       vs_in = 1'b0;
  logic       tbl_wr = 1'b0;
  logic [1:0] tbl_addr = '0;
  logic [7:0] tbl_data = '0;
  logic       invert = 1'b0;

  logic       ce_pix, hblank_out, vblank_out, hs_out, vs_out, de_out;
  logic [7:0] level_out;
  logic       ce1, hb_1, vb_1, hs_1, vs_1, de_1;
  logic [7:0] lvl_1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  video_level_mixer #(.NUM_IN(2), .OUT_W(8), .DIV(DIV)) u_dut (
    .clk_video (clk),        .Reset_I   (rst_n),
    .video_in  (video_in),   .hblank_in (hblank_in),
    .vblank_in (vblank_in),  .hs_in     (hs_in),
    .vs_in     (vs_in),      .tbl_wr    (tbl_wr),
    .tbl_addr  (tbl_addr),   .tbl_data  (tbl_data),
    .invert    (invert),     .ce_pix    (ce_pix),
    .level_out (level_out),  .hblank_out(hblank_out),
    .vblank_out(vblank_out), .hs_out    (hs_out),
    .vs_out    (vs_out),     .de_out    (de_out)
  );

  video_level_mixer #(.NUM_IN(2), .OUT_W(8), .DIV(1)) u_div1 (
    .clk_video (clk),        .Reset_I   (rst_n),
    .video_in  (video_in),   .hblank_in (hblank_in),
    .vblank_in (vblank_in),  .hs_in     (hs_in),
    .vs_in     (vs_in),      .tbl_wr    (tbl_wr),
    .tbl_addr  (tbl_addr),   .tbl_data  (tbl_data),
    .invert    (invert),     .ce_pix    (ce1),
    .level_out (lvl_1),      .hblank_out(hb_1),
    .vblank_out(vb_1),       .hs_out    (hs_1),
    .vs_out    (vs_1),       .de_out    (de_1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: strobe schedule from edge count, samples in a queue.
  typedef struct packed {
    logic [1:0] vid;
    logic       hb, vb, hs, vs;
  } smp_t;

  smp_t       mq[$];
  smp_t       mo;
  logic [7:0] mtbl[4];
  int         e;
  bit         mce, mce1;
  logic [7:0] m_lvl;
  logic       m_hb, m_vb, m_hs, m_vs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e = 0; mce = 0; mce1 = 0;
      mq.delete();
      mq.push_back('0);
      for (int i = 0; i < 4; i++) mtbl[i] = 8'((i * 255) / 3);
      m_lvl = '0; m_hb = 0; m_vb = 0; m_hs = 0; m_vs = 0;
    end else begin
      if (mce) begin
        mq.push_back({video_in, hblank_in, vblank_in, hs_in, vs_in});
        mo = mq.pop_front();
        m_hb = mo.hb; m_vb = mo.vb; m_hs = mo.hs; m_vs = mo.vs;
        m_lvl = (mo.hb | mo.vb) ? 8'h00 : (mtbl[mo.vid] ^ {8{invert}});
      end
      if (tbl_wr) mtbl[tbl_addr] = tbl_data;
      e++;
      mce  = (e >= DIV) && (e % DIV == 0);
      mce1 = 1;
    end
  end

  always @(negedge clk) begin
    chk("model_level", level_out, m_lvl);
    chk("model_timing", {hblank_out, vblank_out, hs_out, vs_out, de_out},
        {m_hb, m_vb, m_hs, m_vs, ~(m_hb | m_vb)});
    chk("model_ce", ce_pix, mce);
    chk("model_ce_div1", ce1, mce1);
  end

  // Literal expectations travel two strobes behind their input sample.
  typedef struct packed {
    logic       v;
    logic [7:0] lvl;
    logic       de, hs, vs;
  } lit_t;

  lit_t lq[$];

  task automatic wait_ce();
    int n = 0;
    while (!mce && n < 64) begin
      @(posedge clk); #2; n++;
    end
    if (!mce) chk("wait_ce_timeout", 0, 1);
  endtask

  task automatic step(input logic [1:0] v, input logic hb, vb, hs, vs, inv,
                      input logic wr, input logic [1:0] wa,
                      input logic [7:0] wd, input logic lv,
                      input logic [7:0] ll, input logic lde, lhs, lvs);
    lit_t l;
    wait_ce();
    if (lq.size() >= 2) begin
      l = lq.pop_front();
      if (l.v) begin
        chk("lit_level", level_out, l.lvl);
        chk("lit_de", de_out, l.de);
        chk("lit_hs", hs_out, l.hs);
        chk("lit_vs", vs_out, l.vs);
      end
    end
    video_in = v; hblank_in = hb; vblank_in = vb;
    hs_in = hs; vs_in = vs; invert = inv;
    tbl_wr = wr; tbl_addr = wa; tbl_data = wd;
    lq.push_back({lv, ll, lde, lhs, lvs});
    @(posedge clk); #2;
    tbl_wr = 0;
  endtask

  task automatic px(input logic [1:0] v, input logic hb, inv,
                    input logic [7:0] ll, input logic lde);
    step(v, hb, 0, 0, 0, inv, 0, 0, 0, 1, ll, lde, 0, 0);
  endtask

  task automatic pad(input int n, input logic inv);
    repeat (n) step(0, 0, 0, 0, 0, inv, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    tbl_wr = 1; tbl_addr = a; tbl_data = d;
    @(posedge clk); #2;
    tbl_wr = 0;
  endtask

  task automatic measure_ce(input string nm, input int exp, input bit first);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (first && n == 1) chk("div1_first_edge", ce1, 1'b1);
    end while (!ce_pix && n < 40);
    chk(nm, n, exp);
  endtask

  initial begin
    #1 rst_n = 0;
    #9;
    chk("rst_level", level_out, 8'h00);
    chk("rst_de", de_out, 1'b1);
    chk("rst_ce", ce_pix, 1'b0);
    chk("rst_sync", {hblank_out, vblank_out, hs_out, vs_out}, 4'b0);
    chk("rst_div1_ce", ce1, 1'b0);
    #10 rst_n = 1;
    measure_ce("first_ce_edges", DIV, 1);
    measure_ce("ce_period", DIV, 0);
    #1;

    // Power-up ramp
    px(0, 0, 0, 8'h00, 1); px(1, 0, 0, 8'h55, 1);
    px(2, 0, 0, 8'hAA, 1); px(3, 0, 0, 8'hFF, 1);
    pad(2, 0);

    // Programmed table, same-cycle write, back-to-back writes
    wr(0, 8'h00); wr(1, 8'h70); wr(2, 8'h86); wr(3, 8'hFF);
    px(1, 0, 0, 8'h70, 1); px(2, 0, 0, 8'h86, 1);
    px(3, 0, 0, 8'hFF, 1); px(0, 0, 0, 8'h00, 1);
    px(2, 0, 0, 8'h86, 1);
    step(2, 0, 0, 0, 0, 0, 1, 2, 8'h33, 1, 8'h33, 1, 0, 0);
    px(2, 0, 0, 8'h33, 1);
    pad(2, 0);
    wr(1, 8'h11); wr(1, 8'h22);
    px(1, 0, 0, 8'h22, 1); px(0, 0, 0, 8'h00, 1);
    pad(2, 0);

    // Blanking with invert
    px(1, 0, 1, 8'hDD, 1);
    px(3, 1, 1, 8'h00, 0); px(3, 1, 1, 8'h00, 0); px(3, 1, 1, 8'h00, 0);
    px(3, 0, 1, 8'h00, 1); px(1, 0, 1, 8'hDD, 1);
    pad(2, 1);
    pad(2, 0);

    // Sync edges
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h22, 1, 0, 0);
    step(2, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8'h33, 1, 1, 0);
    step(3, 0, 0, 1, 1, 0, 0, 0, 0, 1, 8'hFF, 1, 1, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h00, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h22, 1, 0, 0);
    step(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    chk("pre_rst_level", level_out, 8'h22);

    // Mid-line reset
    rst_n = 0;
    #1;
    chk("midrst_level", level_out, 8'h00);
    chk("midrst_de", de_out, 1'b1);
    chk("midrst_ce", ce_pix, 1'b0);
    chk("midrst_sync", {hblank_out, vblank_out, hs_out, vs_out}, 4'b0);
    lq.delete();
    video_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    measure_ce("rst_ce_edges", DIV, 0);
    #1;
    px(0, 0, 0, 8'h00, 1); px(1, 0, 0, 8'h55, 1);
    px(2, 0, 0, 8'hAA, 1); px(3, 0, 0, 8'hFF, 1);
    pad(2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
